whack_core: RTL

- Parametrised whack-a-mole game engine for N holes: pseudo-random mole spawning, per-mole lifetime, game countdown, score and miss accounting.
- Sits between the debounced button pulses and the LEDs/score display. Supersedes the fixed 5-mole, one-mole-per-second arrangement.
- Adds concurrent moles, mole expiry with miss counting, a game timer, restart, and saturating counters.

---
 rtl/whack_if.sv | 29 ++
 rtl/whack_core.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/whack_if.sv
// whack_if: game-engine bus between button/LED glue and whack_core (Rev 1.0).
`default_nettype none

interface whack_if #(
  parameter int N_MOLES = 5,
  parameter int SCORE_W = 8,
  parameter int TIME_W  = 6
) ();
  logic               start_pulse;
  logic [N_MOLES-1:0] hit_pulse;
  logic [N_MOLES-1:0] mole_led;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] misses;
  logic [TIME_W-1:0]  time_left;
  logic               game_active;
  logic               game_over;

  modport master (
    output start_pulse, hit_pulse,
    input  mole_led, score, misses, time_left, game_active, game_over
  );

  modport slave (
    input  start_pulse, hit_pulse,
    output mole_led, score, misses, time_left, game_active, game_over
  );
endinterface

`default_nettype wire

// File: rtl/whack_core.sv
// whack_core: N-hole whack-a-mole engine (spawn, expiry, countdown, scoring), Rev 1.0.
// Optional WHACK_CORE_MISS_PENALTY_EN: presses on unlit holes cost one point each.
`default_nettype none

module whack_core #(
  parameter int          N_MOLES    = 5,
  parameter int          MAX_ACTIVE = 1,
  parameter int          MOLE_LIFE  = 2,
  parameter int          GAME_TICKS = 30,
  parameter int          TICK_DIV   = 100_000_000,
  parameter int          SCORE_W    = 8,
  parameter int          TIME_W     = 6,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic    clock,
  input  logic    reset,
  whack_if.slave  bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AGE_W = $clog2(MOLE_LIFE + 1);
  localparam int IDX_W = $clog2(N_MOLES);
  localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [15:0]        LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [N_MOLES-1:0] led_q, led_d;
  logic [AGE_W-1:0]   age_q [N_MOLES];
  logic [AGE_W-1:0]   age_d [N_MOLES];
  logic [SCORE_W-1:0] score_q, score_d, misses_q, misses_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic               active_q, active_d, over_q, over_d;

  logic [N_MOLES-1:0] hits, led_nx, expired;
  logic [SCORE_W-1:0] score_nx;
  logic [IDX_W-1:0]   spawn_idx;
  logic               tick;

  function automatic int popcnt(input logic [N_MOLES-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N_MOLES; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s > int'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(s);
  endfunction

`ifdef WHACK_CORE_MISS_PENALTY_EN
  function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] a, input int b);
    int s;
    s = int'(a) - b;
    return (s < 0) ? '0 : SCORE_W'(s);
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    led_d     = led_q;
    age_d     = age_q;
    score_d   = score_q;
    misses_d  = misses_q;
    time_d    = time_q;
    active_d  = active_q;
    over_d    = over_q;
    hits      = bus.hit_pulse & led_q;
    led_nx    = led_q & ~hits;
    expired   = '0;
    score_nx  = sat_add(score_q, popcnt(hits));
`ifdef WHACK_CORE_MISS_PENALTY_EN
    score_nx  = sat_sub(score_nx, popcnt(bus.hit_pulse & ~led_q));
`endif
    tick      = (cnt_q == TICK_LAST);
    spawn_idx = IDX_W'(32'(lfsr_q) % N_MOLES);

    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start_pulse) begin
          state_d  = S_PLAY;
          cnt_d    = '0;
          led_d    = '0;
          score_d  = '0;
          misses_d = '0;
          time_d   = TIME_W'(GAME_TICKS);
          active_d = 1'b1;
          over_d   = 1'b0;
          for (int i = 0; i < N_MOLES; i++) age_d[i] = '0;
        end
      end
      S_PLAY: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          for (int i = 0; i < N_MOLES; i++) begin
            if (led_nx[i]) begin
              if (int'(age_q[i]) + 1 >= MOLE_LIFE) begin
                led_nx[i]  = 1'b0;
                expired[i] = 1'b1;
              end else begin
                age_d[i] = age_q[i] + 1'b1;
              end
            end
          end
          misses_d = sat_add(misses_q, popcnt(expired));
          // A hole hit this very cycle is not eligible for the spawn.
          if (popcnt(led_nx) < MAX_ACTIVE && !led_nx[spawn_idx] && !hits[spawn_idx]) begin
            led_nx[spawn_idx] = 1'b1;
            age_d[spawn_idx]  = '0;
          end
          time_d = time_q - 1'b1;
          if (time_q == TIME_W'(1)) begin
            state_d  = S_OVER;
            led_nx   = '0;
            active_d = 1'b0;
            over_d   = 1'b1;
          end
        end
        led_d   = led_nx;
        score_d = score_nx;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      led_q    <= '0;
      score_q  <= '0;
      misses_q <= '0;
      time_q   <= '0;
      active_q <= 1'b0;
      over_q   <= 1'b0;
      for (int i = 0; i < N_MOLES; i++) age_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      led_q    <= led_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      time_q   <= time_d;
      active_q <= active_d;
      over_q   <= over_d;
      for (int i = 0; i < N_MOLES; i++) age_q[i] <= age_d[i];
    end
  end

  assign bus.mole_led    = led_q;
  assign bus.score       = score_q;
  assign bus.misses      = misses_q;
  assign bus.time_left   = time_q;
  assign bus.game_active = active_q;
  assign bus.game_over   = over_q;

endmodule

`default_nettype wire
